// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sine-table path: default widths, table depth
// and the loader state encoding.
package nco_pkg;

  localparam int NCO_ADDR_W  = 8;
  localparam int NCO_DATA_W  = 16;
  localparam int TABLE_DEPTH = 2 ** (NCO_ADDR_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sine_table_loader.sv
// Streams 2*2**ADDR_W samples into the two sine-table banks in order, driving
// the RAM write ports with one-cycle registered latency and a running checksum.
module sine_table_loader
  import nco_pkg::*;
#(
  parameter int ADDR_W = NCO_ADDR_W,
  parameter int DATA_W = NCO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              csb00,
  output logic [ADDR_W-1:0] addr00,
  output logic [DATA_W-1:0] din00,
  output logic              csb01,
  output logic [ADDR_W-1:0] addr01,
  output logic [DATA_W-1:0] din01,
  output logic              busy,
  output logic              done,
  output logic              loaded,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] LAST_IDX = '1;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                loaded_q, loaded_d;
  logic                accept;

  assign s_ready = (state_q == LOAD) && !abort;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    checksum_d = checksum_q;
    loaded_d   = loaded_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = LOAD;
          idx_d      = '0;
          checksum_d = '0;
          loaded_d   = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          idx_d      = idx_q + 1'b1;
          checksum_d = checksum_q + s_data;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      checksum_q <= '0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      checksum_q <= checksum_d;
      loaded_q   <= loaded_d;
    end
  end

  // Top index bit picks the bank; the idle bank keeps its last addr/din.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic              hit;
    logic              csb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;

    assign hit = accept && (int'(idx_q[ADDR_W]) == gi);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        csb_q  <= 1'b1;
        addr_q <= '0;
        din_q  <= '0;
      end else begin
        csb_q <= !hit;
        if (hit) begin
          addr_q <= idx_q[ADDR_W-1:0];
          din_q  <= s_data;
        end
      end
    end
  end

  assign csb00    = g_bank[0].csb_q;
  assign addr00   = g_bank[0].addr_q;
  assign din00    = g_bank[0].din_q;
  assign csb01    = g_bank[1].csb_q;
  assign addr01   = g_bank[1].addr_q;
  assign din01    = g_bank[1].din_q;
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign loaded   = loaded_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_sine_table_loader.sv
// Self-checking bench for sine_table_loader: randomized sample streams compared
// against a cycle-level behavioural model of the load sequence.
module tb_sine_table_loader;
  import nco_pkg::*;

  localparam int AW    = NCO_ADDR_W;
  localparam int DW    = NCO_DATA_W;
  localparam int DEPTH = TABLE_DEPTH;
  localparam int HALF  = DEPTH / 2;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          csb00, csb01;
  logic [AW-1:0] addr00, addr01;
  logic [DW-1:0] din00, din01;
  logic          busy, done, loaded;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  int phase;
  int m_idx;
  int m_sum;
  bit m_loaded;
  int exp_addr[2];
  int exp_din[2];
  int done_seen;
  int wr_count[2];

  always #5 clk = ~clk;

  sine_table_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .csb00(csb00), .addr00(addr00), .din00(din00),
    .csb01(csb01), .addr01(addr01), .din01(din01),
    .busy(busy), .done(done), .loaded(loaded), .checksum(checksum)
  );

  task automatic reset_model();
    phase = PH_IDLE; m_idx = 0; m_sum = 0; m_loaded = 0;
    exp_addr[0] = 0; exp_addr[1] = 0; exp_din[0] = 0; exp_din[1] = 0;
  endtask

  task automatic clear_counts();
    done_seen = 0; wr_count[0] = 0; wr_count[1] = 0;
  endtask

  // One clock of stimulus: starts and ends at a falling edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit ab, input bit st);
    bit acc;
    int bank;
    s_valid = v; s_data = d; abort = ab; start = st;
    #1;
    checks++;
    if (s_ready !== ((phase == PH_LOAD) && !ab)) begin
      errors++;
      $display("FAIL s_ready got %0b want %0b at idx %0d", s_ready, (phase == PH_LOAD) && !ab, m_idx);
    end
    acc  = (phase == PH_LOAD) && !ab && v;
    bank = m_idx / HALF;
    case (phase)
      PH_IDLE: if (st && !ab) begin phase = PH_LOAD; m_idx = 0; m_sum = 0; m_loaded = 0; end
      PH_LOAD: begin
        if (ab) phase = PH_IDLE;
        else if (acc) begin
          exp_addr[bank] = m_idx % HALF;
          exp_din[bank]  = int'(d);
          m_sum = (m_sum + int'(d)) % (2 ** DW);
          m_idx++;
          if (m_idx == DEPTH) phase = PH_DONE;
        end
      end
      default: begin m_loaded = 1; phase = PH_IDLE; end
    endcase
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (csb00 !== !(acc && bank == 0) || csb01 !== !(acc && bank == 1)) begin
      errors++;
      $display("FAIL csb got %0b%0b want %0b%0b idx %0d", csb00, csb01, !(acc && bank == 0), !(acc && bank == 1), m_idx);
    end
    checks++;
    if (csb00 === 1'b0 && csb01 === 1'b0) begin
      errors++;
      $display("FAIL both_csb_low got 00 want not-both-low idx %0d", m_idx);
    end
    checks++;
    if (addr00 !== AW'(exp_addr[0]) || din00 !== DW'(exp_din[0])) begin
      errors++;
      $display("FAIL bank0_port got %0h/%0h want %0h/%0h", addr00, din00, exp_addr[0], exp_din[0]);
    end
    checks++;
    if (addr01 !== AW'(exp_addr[1]) || din01 !== DW'(exp_din[1])) begin
      errors++;
      $display("FAIL bank1_port got %0h/%0h want %0h/%0h", addr01, din01, exp_addr[1], exp_din[1]);
    end
    checks++;
    if (busy !== (phase == PH_LOAD) || done !== (phase == PH_DONE) || loaded !== m_loaded) begin
      errors++;
      $display("FAIL status got b%0b d%0b l%0b want b%0b d%0b l%0b", busy, done, loaded,
               phase == PH_LOAD, phase == PH_DONE, m_loaded);
    end
    checks++;
    if (checksum !== DW'(m_sum)) begin
      errors++;
      $display("FAIL checksum got %0h want %0h", checksum, m_sum);
    end
    if (done === 1'b1) done_seen++;
    if (csb00 === 1'b0) wr_count[0]++;
    if (csb01 === 1'b0) wr_count[1]++;
  endtask

  task automatic test_reset();
    s_valid = 0; start = 0; abort = 0; s_data = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (csb00 !== 1 || csb01 !== 1 || addr00 !== '0 || addr01 !== '0 || din00 !== '0 || din01 !== '0 ||
        busy !== 0 || done !== 0 || loaded !== 0 || checksum !== '0) begin
      errors++;
      $display("FAIL reset_values got csb%0b%0b busy%0b done%0b loaded%0b sum%0h want all idle", csb00, csb01, busy, done, loaded, checksum);
    end
    rst = 1'b0;
    reset_model();
    clear_counts();
    // abort alone in IDLE must change nothing
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    // abort wins over start
    step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_full_load();
    clear_counts();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == HALF - 1) begin
        checks++;
        if (csb00 !== 1'b0 || addr00 !== 8'hFF || csb01 !== 1'b1) begin
          errors++;
          $display("FAIL boundary_255 got csb%0b%0b addr00 %0h want csb01 addr00 ff", csb00, csb01, addr00);
        end
      end
      if (i == HALF) begin
        checks++;
        if (csb01 !== 1'b0 || addr01 !== 8'h00 || csb00 !== 1'b1) begin
          errors++;
          $display("FAIL boundary_256 got csb%0b%0b addr01 %0h want csb10 addr01 00", csb00, csb01, addr01);
        end
      end
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (checksum !== 16'hFF00 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL full_load_final got sum %0h loaded %0b want ff00 1", checksum, loaded);
    end
    checks++;
    if (done_seen != 1 || wr_count[0] != HALF || wr_count[1] != HALF) begin
      errors++;
      $display("FAIL full_load_counts got done %0d wr %0d/%0d want 1 256/256", done_seen, wr_count[0], wr_count[1]);
    end
  endtask

  task automatic test_toggle_valid();
    int cycles;
    bit finished;
    clear_counts();
    finished = 0;
    cycles = 0;
    step(1'b0, '0, 1'b0, 1'b1);
    cycles = 1;
    for (int c = 0; c < 3000 && !finished; c++) begin
      step((c % 2) == 0, DW'($urandom), 1'b0, 1'b0);
      cycles++;
      if (done === 1'b1) finished = 1;
    end
    checks++;
    if (!finished || cycles != 2 * DEPTH) begin
      errors++;
      $display("FAIL toggle_done_latency got %0d cycles (finished %0b) want %0d", cycles, finished, 2 * DEPTH);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (done_seen != 1 || wr_count[0] != HALF || wr_count[1] != HALF) begin
      errors++;
      $display("FAIL toggle_counts got done %0d wr %0d/%0d want 1 256/256", done_seen, wr_count[0], wr_count[1]);
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] first;
    clear_counts();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 1000 && m_idx < 100; c++) step(1'(($urandom % 2)), DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'($urandom), 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0 || loaded !== 1'b0 || done_seen != 0 || wr_count[0] != 100) begin
      errors++;
      $display("FAIL abort_state got busy %0b loaded %0b done %0d wr %0d want 0 0 0 100", busy, loaded, done_seen, wr_count[0]);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    clear_counts();
    step(1'b0, '0, 1'b0, 1'b1);
    first = DW'($urandom);
    step(1'b1, first, 1'b0, 1'b0);
    checks++;
    if (csb00 !== 1'b0 || addr00 !== '0 || checksum !== first) begin
      errors++;
      $display("FAIL restart got csb00 %0b addr %0h sum %0h want 0 0 %0h", csb00, addr00, checksum, first);
    end
    for (int c = 0; c < 5000 && phase != PH_IDLE; c++) step(1'(($urandom % 4) != 0), DW'($urandom), 1'b0, 1'b0);
    checks++;
    if (done_seen != 1 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL restart_complete got done %0d loaded %0b want 1 1", done_seen, loaded);
    end
  endtask

  task automatic test_start_mid_load();
    clear_counts();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 2000 && m_idx < 300; c++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'($urandom), 1'b0, 1'b1);
    for (int c = 0; c < 2000 && phase != PH_IDLE; c++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    checks++;
    if (done_seen != 1 || wr_count[0] != HALF || wr_count[1] != HALF || loaded !== 1'b1) begin
      errors++;
      $display("FAIL start_mid_load got done %0d wr %0d/%0d loaded %0b want 1 256/256 1", done_seen, wr_count[0], wr_count[1], loaded);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 50; c++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = DW'($urandom);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (csb00 !== 1 || csb01 !== 1 || addr00 !== '0 || addr01 !== '0 || din00 !== '0 || din01 !== '0 ||
        busy !== 0 || done !== 0 || loaded !== 0 || checksum !== '0) begin
      errors++;
      $display("FAIL async_reset got csb%0b%0b addr%0h/%0h busy%0b sum%0h want idle zeros", csb00, csb01, addr00, addr01, busy, checksum);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
  endtask

  initial begin
    reset_model();
    clear_counts();
    test_reset();
    test_full_load();
    test_toggle_valid();
    test_abort();
    test_start_mid_load();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
